// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, runs a single-outstanding ibus
// handshake and buffers fetched instructions in a DEPTH-entry FIFO for decode.
module fetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_addr_ok,
    input  logic            iresp_data_ok,
    input  logic [ILEN-1:0] iresp_data,
    input  logic            ls_busy,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    input  logic            out_ready
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             drop, drop_next;
    logic [XLEN-1:0]  fetch_pc, fetch_pc_next, ireq_addr_next;
    logic             resp_done, push, pop, wr_en;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [CNT_W-1:0] count, count_next, occ_after_pop;
    logic [XLEN-1:0]  out_pc_next;
    logic [ILEN-1:0]  out_instr_next;

    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [ILEN-1:0]  mem_instr [DEPTH];

    // Request FSM, fetch PC and stale-response tracking
    always_comb begin
        state_next     = state;
        drop_next      = drop;
        fetch_pc_next  = fetch_pc;
        resp_done      = 1'b0;
        push           = 1'b0;
        ireq_addr_next = ireq_addr;

        case (state)
            IDLE: begin
                if (!ls_busy && (count < FULL_CNT)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (iresp_addr_ok) begin
                    if (iresp_data_ok) begin
                        state_next = IDLE;
                        resp_done  = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (iresp_data_ok) begin
                    state_next = IDLE;
                    resp_done  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        push = resp_done && !drop && !redirect_valid;
        if (push) begin
            fetch_pc_next = fetch_pc + XLEN'(4);
        end
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & ~XLEN'(3);
        end

        // A response that completes always clears drop; otherwise a redirect
        // with a request on the bus marks that response as stale.
        if (resp_done) begin
            drop_next = 1'b0;
        end else if (redirect_valid && (state != IDLE)) begin
            drop_next = 1'b1;
        end

        // Address is frozen while a request is presented and not yet accepted.
        if (!((state == REQ) && (state_next == REQ))) begin
            ireq_addr_next = fetch_pc_next;
        end
    end

    // FIFO pointer/count update and registered head selection
    always_comb begin
        pop            = out_valid && out_ready && !redirect_valid;
        wr_en          = push && ((count < FULL_CNT) || pop);
        occ_after_pop  = count - CNT_W'(pop);
        rd_ptr_next    = rd_ptr + PTR_W'(pop);
        wr_ptr_next    = wr_ptr + PTR_W'(wr_en);
        count_next     = occ_after_pop + CNT_W'(wr_en);
        out_pc_next    = out_pc;
        out_instr_next = out_instr;

        if (redirect_valid) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end

        if (count_next != '0) begin
            if (wr_en && (occ_after_pop == '0)) begin
                out_pc_next    = fetch_pc;
                out_instr_next = iresp_data;
            end else begin
                out_pc_next    = mem_pc[rd_ptr_next];
                out_instr_next = mem_instr[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            drop       <= 1'b0;
            fetch_pc   <= RESET_PC;
            ireq_valid <= 1'b0;
            ireq_addr  <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= '0;
        end else begin
            state      <= state_next;
            drop       <= drop_next;
            fetch_pc   <= fetch_pc_next;
            ireq_valid <= (state_next == REQ);
            ireq_addr  <= ireq_addr_next;
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= wr_ptr_next;
            count      <= count_next;
            out_valid  <= (count_next != '0);
            out_pc     <= out_pc_next;
            out_instr  <= out_instr_next;
        end
    end

    // Storage needs no reset: entries are only read once count covers them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_instr[wr_ptr] <= iresp_data;
        end
    end

endmodule
